// File: rtl/ieee754_to_fixed_if.sv
// ieee754_to_fixed_if: float-in / fixed-out handshake bundle.
// Rev 1.0
`default_nettype none

interface ieee754_to_fixed_if #(
  parameter int MANTISSA_LENGTH = 23,
  parameter int INT_BITS        = 12,
  parameter int FRAC_BITS       = 12
);
  localparam int W = INT_BITS + FRAC_BITS;

  logic [MANTISSA_LENGTH+8:0] in_float;
  logic                       in_valid;
  logic                       in_ready;
  logic [W-1:0]               out_fixed;
  logic                       out_ovf;
  logic                       out_nan;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_float, in_valid, out_ready,
    input  in_ready, out_fixed, out_ovf, out_nan, out_valid
  );

  modport slave (
    input  in_float, in_valid, out_ready,
    output in_ready, out_fixed, out_ovf, out_nan, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/ieee754_to_fixed.sv
// ieee754_to_fixed: iterative float -> signed fixed converter, one alignment bit per cycle.
// Rev 1.0
`default_nettype none

module ieee754_to_fixed #(
  parameter int MANTISSA_LENGTH = 23,
  parameter int INT_BITS        = 12,
  parameter int FRAC_BITS       = 12
) (
  input  logic clk,
  input  logic rst_n,
  ieee754_to_fixed_if.slave bus
);
  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int MW = MANTISSA_LENGTH + W + 2;
  localparam int SW = 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [SW-1:0] S_OFF = SW'(FRAC_BITS - MANTISSA_LENGTH - 127);
  localparam logic signed [SW-1:0] S_MAX = SW'(W);
  localparam logic signed [SW-1:0] S_MIN = SW'(-(MANTISSA_LENGTH + 2));
  localparam logic [W-1:0]  POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_MAX = {1'b1, {(W-1){1'b0}}};
  localparam logic [MW-1:0] LIM     = {{(MW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [MW-1:0] LIM_M1  = LIM - MW'(1);

  logic [1:0]    state_q, state_d;
  logic          sign_q, sign_d;
  logic          left_q, left_d;
  logic          guard_q, guard_d;
  logic [MW-1:0] mag_q, mag_d;
  logic [SW-1:0] count_q, count_d;
  logic [W-1:0]  fixed_q, fixed_d;
  logic          ovf_q, ovf_d;
  logic          nan_q, nan_d;

  logic                       f_sign;
  logic [7:0]                 f_exp;
  logic [MANTISSA_LENGTH-1:0] f_mant;
  logic signed [SW-1:0]       s_w;
  logic [SW-1:0]              s_abs;
  logic [MW-1:0]              mag_shl;
  logic [MW-1:0]              r_w;

  assign {f_sign, f_exp, f_mant} = bus.in_float;
  assign s_w     = $signed({{(SW-8){1'b0}}, f_exp}) + S_OFF;
  assign s_abs   = s_w[SW-1] ? SW'(-s_w) : SW'(s_w);
  assign mag_shl = {mag_q[MW-2:0], 1'b0};
  assign r_w     = mag_q + MW'(guard_q);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    left_d  = left_q;
    guard_d = guard_q;
    mag_d   = mag_q;
    count_d = count_q;
    fixed_d = fixed_q;
    ovf_d   = ovf_q;
    nan_d   = nan_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = f_sign;
          left_d  = !s_w[SW-1];
          guard_d = 1'b0;
          mag_d   = {{(MW-MANTISSA_LENGTH-1){1'b0}}, 1'b1, f_mant};
          count_d = s_abs;
          state_d = DONE;
          // Specials and out-of-range exponents resolve on the accept edge.
          if (f_exp == 8'h00) begin
            fixed_d = '0; ovf_d = 1'b0; nan_d = 1'b0;
          end else if (f_exp == 8'hFF) begin
            if (f_mant == '0) begin
              fixed_d = f_sign ? NEG_MAX : POS_MAX; ovf_d = 1'b1; nan_d = 1'b0;
            end else begin
              fixed_d = '0; ovf_d = 1'b0; nan_d = 1'b1;
            end
          end else if (s_w > S_MAX) begin
            fixed_d = f_sign ? NEG_MAX : POS_MAX; ovf_d = 1'b1; nan_d = 1'b0;
          end else if (s_w < S_MIN) begin
            fixed_d = '0; ovf_d = 1'b0; nan_d = 1'b0;
          end else if (s_w == '0) begin
            state_d = ROUND;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        count_d = count_q - SW'(1);
        if (count_q == SW'(1)) state_d = ROUND;
        if (left_q) begin
          if (mag_shl > LIM) begin
            fixed_d = sign_q ? NEG_MAX : POS_MAX; ovf_d = 1'b1; nan_d = 1'b0;
            state_d = DONE;
          end else begin
            mag_d = mag_shl;
          end
        end else begin
          guard_d = mag_q[0];
          mag_d   = {1'b0, mag_q[MW-1:1]};
        end
      end
      ROUND: begin
        nan_d   = 1'b0;
        state_d = DONE;
        // Negative side admits one extra magnitude step: -2^(W-1) is exact.
        if (!sign_q) begin
          if (r_w > LIM_M1) begin
            fixed_d = POS_MAX; ovf_d = 1'b1;
          end else begin
            fixed_d = r_w[W-1:0]; ovf_d = 1'b0;
          end
        end else begin
          if (r_w > LIM) begin
            fixed_d = NEG_MAX; ovf_d = 1'b1;
          end else begin
            fixed_d = W'(0) - r_w[W-1:0]; ovf_d = 1'b0;
          end
        end
      end
      default: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      guard_q <= 1'b0;
      mag_q   <= '0;
      count_q <= '0;
      fixed_q <= '0;
      ovf_q   <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      left_q  <= left_d;
      guard_q <= guard_d;
      mag_q   <= mag_d;
      count_q <= count_d;
      fixed_q <= fixed_d;
      ovf_q   <= ovf_d;
      nan_q   <= nan_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_fixed = fixed_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_nan   = nan_q;

endmodule

`default_nettype wire

// File: tb/tb_ieee754_to_fixed.sv
// tb_ieee754_to_fixed: directed spec vectors plus random floats against a value-level model.
// Rev 1.0
`default_nettype none

module tb_ieee754_to_fixed;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ieee754_to_fixed_if #(.MANTISSA_LENGTH(23), .INT_BITS(12), .FRAC_BITS(12)) u_if ();

  ieee754_to_fixed #(.MANTISSA_LENGTH(23), .INT_BITS(12), .FRAC_BITS(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Value-level reference: x = 1.mant * 2^(e-127), scaled by 2^12, magnitude rounded half-up.
  function automatic void ref_model(input logic [31:0] f, output logic [23:0] fx,
                                    output logic ovf, output logic nan, output int lat);
    int     e    = int'(f[30:23]);
    longint m    = longint'({1'b1, f[22:0]});
    int     s    = e - 127 + 12 - 23;
    longint lim  = longint'(1) << 23;
    longint mag;
    longint neg;
    fx = '0; ovf = 1'b0; nan = 1'b0; lat = 0;
    if (e == 0) return;
    if (e == 255) begin
      if (f[22:0] == 23'd0) begin fx = f[31] ? 24'h800000 : 24'h7FFFFF; ovf = 1'b1; end
      else nan = 1'b1;
      return;
    end
    if (s > 24) begin fx = f[31] ? 24'h800000 : 24'h7FFFFF; ovf = 1'b1; return; end
    if (s < -25) return;
    if (s >= 0) begin mag = m << s; lat = 1; end
    else begin mag = (m + (longint'(1) << (-s - 1))) >> (-s); lat = -s + 1; end
    if (!f[31]) begin
      if (mag > lim - 1) begin fx = 24'h7FFFFF; ovf = 1'b1; end
      else fx = mag[23:0];
    end else begin
      if (mag > lim) begin fx = 24'h800000; ovf = 1'b1; end
      else begin neg = -mag; fx = neg[23:0]; end
    end
  endfunction

  // Entered and left at #1 after a posedge; completes both handshakes with out_ready=1.
  task automatic run_conv(input logic [31:0] f, output logic [23:0] fx, output logic ovf,
                          output logic nan, output int lat);
    int wait_n = 0;
    u_if.in_float = f;
    u_if.in_valid = 1'b1;
    while (!u_if.in_ready && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
    if (!u_if.in_ready) check("accept_timeout", 32'(u_if.in_ready), 32'd1);
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    check($sformatf("busy_%h", f), 32'(u_if.in_ready), 32'd0);
    lat = 0;
    while (!u_if.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check($sformatf("valid_%h", f), 32'(u_if.out_valid), 32'd1);
    fx  = u_if.out_fixed;
    ovf = u_if.out_ovf;
    nan = u_if.out_nan;
    @(posedge clk); #1;
    check($sformatf("release_%h", f), 32'({u_if.out_valid, u_if.in_ready}), 32'b01);
  endtask

  typedef struct {
    logic [31:0] f;
    logic [23:0] fx;
    logic        ovf;
    logic        nan;
    int          lat;
  } vec_t;

  vec_t dir[$] = '{
    '{32'h3F800000, 24'h001000, 1'b0, 1'b0, 12},
    '{32'hC0200000, 24'hFFD800, 1'b0, 1'b0, 11},
    '{32'h39000000, 24'h000001, 1'b0, 1'b0, 25},
    '{32'h45800000, 24'h7FFFFF, 1'b1, 1'b0, 1},
    '{32'hC5000000, 24'h800000, 1'b0, 1'b0, 1},
    '{32'h457FFFFF, 24'h7FFFFF, 1'b1, 1'b0, 1},
    '{32'h7FC00000, 24'h000000, 1'b0, 1'b1, 0},
    '{32'hFF800000, 24'h800000, 1'b1, 1'b0, 0},
    '{32'h80000000, 24'h000000, 1'b0, 1'b0, 0},
    '{32'hBF000000, 24'hFFF800, 1'b0, 1'b0, 13},
    '{32'hB8800000, 24'h000000, 1'b0, 1'b0, 26},
    '{32'h33800000, 24'h000000, 1'b0, 1'b0, 0}
  };

  initial begin
    logic [23:0] fx, efx;
    logic        ovf, nan, eovf, enan;
    int          lat, elat;
    logic [31:0] f;

    rst_n = 1'b0;
    u_if.in_float  = '0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({u_if.out_fixed, u_if.out_ovf, u_if.out_nan,
                              u_if.out_valid, u_if.in_ready}), 32'h1);
    rst_n = 1'b1;

    foreach (dir[i]) begin
      run_conv(dir[i].f, fx, ovf, nan, lat);
      check($sformatf("fixed_%h", dir[i].f), 32'(fx), 32'(dir[i].fx));
      check($sformatf("flags_%h", dir[i].f), 32'({ovf, nan}), 32'({dir[i].ovf, dir[i].nan}));
      check($sformatf("lat_%h", dir[i].f), 32'(lat), 32'(dir[i].lat));
    end

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(9) == 0) f = $urandom();
      else f = {1'($urandom()), 8'($urandom_range(145, 105)), 23'($urandom())};
      ref_model(f, efx, eovf, enan, elat);
      run_conv(f, fx, ovf, nan, lat);
      check($sformatf("rnd_fixed_%h", f), 32'(fx), 32'(efx));
      check($sformatf("rnd_flags_%h", f), 32'({ovf, nan}), 32'({eovf, enan}));
      check($sformatf("rnd_lat_%h", f), 32'(lat), 32'(elat));
    end

    // Back-pressure: hold DONE, present a competing input, then release.
    u_if.out_ready = 1'b0;
    u_if.in_float  = 32'h3F800000;
    u_if.in_valid  = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    lat = 0;
    while (!u_if.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp_valid", 32'(u_if.out_valid), 32'd1);
    u_if.in_float = 32'h40000000;
    u_if.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold", 32'({u_if.out_fixed, u_if.out_ovf, u_if.out_nan,
                            u_if.out_valid, u_if.in_ready}), {8'h0, 24'h001000} << 4 | 32'h2);
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'({u_if.out_valid, u_if.in_ready}), 32'b01);

    // Reset during SHIFT discards the conversion and clears the outputs.
    run_conv(32'hFF800000, fx, ovf, nan, lat);
    u_if.in_float = 32'h3F800000;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid", 32'({u_if.out_fixed, u_if.out_ovf, u_if.out_nan,
                          u_if.out_valid, u_if.in_ready}), 32'h1);
    run_conv(32'h3F800000, fx, ovf, nan, lat);
    check("post_rst_fixed", 32'(fx), 32'h001000);
    check("post_rst_flags", 32'({ovf, nan}), 32'b00);
    check("post_rst_lat", 32'(lat), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
